// File: rtl/ssf_sched_pkg.sv
// Shared types and constants for the ssf core scheduler: FSM states, request encoding,
// index width and a ceiling-log2 helper used to size the stagger counter.
package ssf_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } sched_state_t;

  localparam logic [1:0] REQ_ACTIVE = 2'b01;
  localparam int         IDX_W      = 6;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/ssf_rr_arbiter.sv
// N-way round-robin arbiter with hold-while-busy: the current grantee keeps the grant while it
// requests; otherwise the search starts at the slot after the last grantee. Grant is combinational.
module ssf_rr_arbiter
  import ssf_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_q, last_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] start_w;
  logic [IDX_W-1:0] pos_w;
  logic [IDX_W:0]   sum_w;
  logic [2*N-1:0]   rot_w;

  always_comb begin
    if (busy_q) begin
      start_w = last_q;
    end else if (last_q == IDX_W'(N - 1)) begin
      start_w = '0;
    end else begin
      start_w = last_q + 1'b1;
    end

    // Doubling the request vector turns the wrap-around search into a plain lowest-bit find.
    rot_w     = {req, req} >> start_w;
    gnt_valid = 1'b0;
    pos_w     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_w[i]) begin
        gnt_valid = 1'b1;
        pos_w     = IDX_W'(i);
      end
    end

    sum_w = {1'b0, start_w} + {1'b0, pos_w};
    if (sum_w >= (IDX_W + 1)'(N)) begin
      sum_w = sum_w - (IDX_W + 1)'(N);
    end
    gnt_idx = gnt_valid ? sum_w[IDX_W-1:0] : last_q;

    last_d = gnt_idx;
    busy_d = gnt_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      busy_q <= 1'b0;
    end else begin
      last_q <= last_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/ssf_core_scheduler.sv
// Launches N ssf cores out of reset STAGGER cycles apart, then shares one io bus among them.
// Optional SSF_SCHED_COLLISION_CNT_EN adds a saturating 16-bit collision cycle counter.
module ssf_core_scheduler
  import ssf_sched_pkg::*;
#(
  parameter int N_CORES = 27,
  parameter int STAGGER = 1210,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_CORES-1:0]    core_rst,
  input  logic [2*N_CORES-1:0]  core_req_in,
  input  logic [2*N_CORES-1:0]  core_out_en,
  input  logic [DW*N_CORES-1:0] core_io_out,
  output logic [1:0]            req_in,
  output logic [DW-1:0]         io_out,
  output logic [1:0]            out_en,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  launch_done,
  output logic                  collision
`ifdef SSF_SCHED_COLLISION_CNT_EN
  ,
  output logic [15:0]           collision_cnt
`endif
);

  localparam int CNT_W = clog2(STAGGER);

  sched_state_t        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [N_CORES-1:0]  core_rst_q, core_rst_d;
  logic                launch_done_q, launch_done_d;
  logic [1:0]          req_in_q, req_in_d;
  logic [DW-1:0]       io_out_q, io_out_d;
  logic [1:0]          out_en_q, out_en_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic                collision_q, collision_d;
  logic [N_CORES-1:0]  act_w, req_hit_w;
  logic                multi_act_w, last_release_w, stagger_hit_w;
  logic                gnt_valid_w;
  logic [IDX_W-1:0]    gnt_idx_w;
`ifdef SSF_SCHED_COLLISION_CNT_EN
  logic [15:0]         coll_cnt_q, coll_cnt_d;
`endif

  // Cores held in reset are masked out of both the bus arbiter and the request forwarder.
  always_comb begin
    act_w     = '0;
    req_hit_w = '0;
    for (int k = 0; k < N_CORES; k++) begin
      act_w[k]     = (core_out_en[2*k +: 2] == REQ_ACTIVE) && !core_rst_q[k];
      req_hit_w[k] = (core_req_in[2*k +: 2] == REQ_ACTIVE) && !core_rst_q[k];
    end
    multi_act_w = |(act_w & (act_w - N_CORES'(1)));
  end

  ssf_rr_arbiter #(.N(N_CORES)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (act_w),
    .gnt_valid (gnt_valid_w),
    .gnt_idx   (gnt_idx_w)
  );

  assign stagger_hit_w  = (cnt_q == CNT_W'(STAGGER - 1));
  assign last_release_w = (state_q == LAUNCH) && stagger_hit_w &&
                          (int'(k_q) + 1 == N_CORES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      k_q           <= '0;
      core_rst_q    <= '1;
      launch_done_q <= 1'b0;
      req_in_q      <= 2'b00;
      io_out_q      <= '0;
      out_en_q      <= 2'b00;
      grant_idx_q   <= '0;
      collision_q   <= 1'b0;
`ifdef SSF_SCHED_COLLISION_CNT_EN
      coll_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      core_rst_q    <= core_rst_d;
      launch_done_q <= launch_done_d;
      req_in_q      <= req_in_d;
      io_out_q      <= io_out_d;
      out_en_q      <= out_en_d;
      grant_idx_q   <= grant_idx_d;
      collision_q   <= collision_d;
`ifdef SSF_SCHED_COLLISION_CNT_EN
      coll_cnt_q    <= coll_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (N_CORES == 1) ? RUN : LAUNCH;
      LAUNCH:  if (last_release_w) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    k_d           = k_q;
    core_rst_d    = core_rst_q;
    launch_done_d = launch_done_q;
    if (state_q == IDLE && start) begin
      cnt_d         = '0;
      k_d           = '0;
      core_rst_d[0] = 1'b0;
      launch_done_d = (N_CORES == 1);
    end else if (state_q == LAUNCH) begin
      if (stagger_hit_w) begin
        cnt_d         = '0;
        k_d           = k_q + 1'b1;
        core_rst_d    = core_rst_q & ~(N_CORES'(1) << (k_q + 1'b1));
        launch_done_d = last_release_w;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Forwarded request carries only the active code, so any unmasked hit selects it.
    req_in_d = (|req_hit_w) ? REQ_ACTIVE : 2'b00;

    io_out_d    = '0;
    out_en_d    = 2'b00;
    grant_idx_d = grant_idx_q;
    if (gnt_valid_w) begin
      out_en_d    = REQ_ACTIVE;
      grant_idx_d = gnt_idx_w;
      for (int k = 0; k < N_CORES; k++) begin
        if (gnt_idx_w == IDX_W'(k)) io_out_d = core_io_out[DW*k +: DW];
      end
    end

    collision_d = collision_q | multi_act_w;
`ifdef SSF_SCHED_COLLISION_CNT_EN
    coll_cnt_d = coll_cnt_q;
    if (multi_act_w && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
`endif
  end

  assign core_rst    = core_rst_q;
  assign launch_done = launch_done_q;
  assign req_in      = req_in_q;
  assign io_out      = io_out_q;
  assign out_en      = out_en_q;
  assign grant_idx   = grant_idx_q;
  assign collision   = collision_q;
`ifdef SSF_SCHED_COLLISION_CNT_EN
  assign collision_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_ssf_core_scheduler.sv
// Bench for ssf_core_scheduler (N_CORES=4, STAGGER=8, DW=32): a per-cycle reference model pushes
// expected outputs into a queue that a negedge monitor pops and compares.
module tb_ssf_core_scheduler;
  localparam int N  = 4;
  localparam int ST = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [N-1:0]  core_rst;
    logic          done;
    logic          coll;
    logic [1:0]    req;
    logic [1:0]    oe;
    logic [DW-1:0] io;
    logic [5:0]    gidx;
    logic [15:0]   cnt;
  } snap_t;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [N-1:0]    core_rst;
  logic [2*N-1:0]  core_req_in, core_out_en;
  logic [DW*N-1:0] core_io_out;
  logic [1:0]      req_in, out_en;
  logic [DW-1:0]   io_out;
  logic [5:0]      grant_idx;
  logic            launch_done, collision;
`ifdef SSF_SCHED_COLLISION_CNT_EN
  logic [15:0]     collision_cnt;
`endif

  ssf_core_scheduler #(.N_CORES(N), .STAGGER(ST), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_rst    (core_rst),
    .core_req_in (core_req_in),
    .core_out_en (core_out_en),
    .core_io_out (core_io_out),
    .req_in      (req_in),
    .io_out      (io_out),
    .out_en      (out_en),
    .grant_idx   (grant_idx),
    .launch_done (launch_done),
    .collision   (collision)
`ifdef SSF_SCHED_COLLISION_CNT_EN
    ,
    .collision_cnt (collision_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // reference model: outputs as the spec describes them, visible in the current cycle
  snap_t     exp_q[$];
  int        checks = 0;
  int        errors = 0;
  bit        push_en = 0;
  int        m_mode, m_t, m_last, m_cnt;
  bit        m_hold, m_done, m_coll;
  bit [N-1:0] m_rst_v;
  bit [1:0]  m_req, m_oe;
  bit [DW-1:0] m_io;
  int        m_gidx;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_last = 0; m_hold = 0; m_cnt = 0;
    m_done = 0; m_coll = 0; m_rst_v = '1; m_req = 0; m_oe = 0; m_io = 0; m_gidx = 0;
  endtask

  task automatic model_step();
    snap_t s;
    bit [N-1:0] act;
    int nact, w, rel;
    bit any_req;
    if (push_en) begin
      s.core_rst = m_rst_v; s.done = m_done; s.coll = m_coll; s.req = m_req;
      s.oe = m_oe; s.io = m_io; s.gidx = 6'(m_gidx); s.cnt = 16'(m_cnt);
      exp_q.push_back(s);
    end
    if (rst) begin
      model_reset();
      return;
    end
    nact = 0; any_req = 0;
    for (int k = 0; k < N; k++) begin
      act[k] = (core_out_en[2*k +: 2] == 2'b01) && !m_rst_v[k];
      if (act[k]) nact++;
      if ((core_req_in[2*k +: 2] == 2'b01) && !m_rst_v[k]) any_req = 1;
    end
    if (nact > 1) begin
      m_coll = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    m_req = any_req ? 2'b01 : 2'b00;
    w = -1;
    if (m_hold && act[m_last]) w = m_last;
    else begin
      for (int off = 1; off <= N; off++) begin
        if (w < 0 && act[(m_last + off) % N]) w = (m_last + off) % N;
      end
    end
    if (w >= 0) begin
      m_oe = 2'b01; m_io = core_io_out[DW*w +: DW]; m_gidx = w; m_last = w; m_hold = 1;
    end else begin
      m_oe = 2'b00; m_io = '0; m_hold = 0;
    end
    if (m_mode == 0) begin
      if (start) begin
        m_mode = 1; m_t = 0; m_rst_v[0] = 0;
      end
    end else if (m_mode == 1) begin
      m_t++;
      rel = 1 + m_t / ST;
      for (int k = 0; k < N; k++) if (k < rel) m_rst_v[k] = 0;
      if (rel >= N) begin
        m_done = 1; m_mode = 2;
      end
    end
  endtask

  // driver tasks
  task automatic cyc(input bit r, input bit s);
    rst = r; start = s;
    model_step();
    push_en = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_oe(input int k, input logic [1:0] v);
    core_out_en[2*k +: 2] = v;
  endtask

  task automatic set_req(input int k, input logic [1:0] v);
    core_req_in[2*k +: 2] = v;
  endtask

  task automatic set_io(input int k, input logic [DW-1:0] v);
    core_io_out[DW*k +: DW] = v;
  endtask

  task automatic randomize_inputs(input int change_pct);
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 99) < change_pct) set_oe(k, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 99) < change_pct) set_req(k, 2'($urandom_range(0, 3)));
      set_io(k, $urandom);
    end
  endtask

  task automatic quiet_inputs();
    core_out_en = '0; core_req_in = '0;
    for (int k = 0; k < N; k++) set_io(k, 32'h100 + 32'(k));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    snap_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.core_rst = core_rst; a.done = launch_done; a.coll = collision; a.req = req_in;
      a.oe = out_en; a.io = io_out; a.gidx = grant_idx;
`ifdef SSF_SCHED_COLLISION_CNT_EN
      a.cnt = collision_cnt;
`else
      a.cnt = '0; e.cnt = '0;
`endif
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got rst=%b done=%b coll=%b req=%b oe=%b io=%h gidx=%0d cnt=%0d exp rst=%b done=%b coll=%b req=%b oe=%b io=%h gidx=%0d cnt=%0d",
                 $time, a.core_rst, a.done, a.coll, a.req, a.oe, a.io, a.gidx, a.cnt,
                 e.core_rst, e.done, e.coll, e.req, e.oe, e.io, e.gidx, e.cnt);
      end
    end
  end

  task automatic launch_seq();
    cyc(0, 1);
    for (int i = 0; i < 27; i++) begin
      if (i == 5) cyc(0, 1);
      else cyc(0, 0);
    end
  endtask

  initial begin
    model_reset();
    rst = 1; start = 0;
    quiet_inputs();
    // 1: reset, noisy idle (all masked), staggered launch with random activity
    for (int i = 0; i < 3; i++) cyc(1, 0);
    for (int i = 0; i < 4; i++) begin
      randomize_inputs(100);
      cyc(0, 0);
    end
    quiet_inputs();
    launch_seq();
    // 2: cores 1 and 3 collide, core 1 wins, then core 3 after core 1 drops
    set_io(1, 32'h11); set_io(3, 32'h33);
    set_oe(1, 2'b01); set_oe(3, 2'b01);
    for (int i = 0; i < 3; i++) cyc(0, 0);
    set_oe(1, 2'b00);
    for (int i = 0; i < 3; i++) cyc(0, 0);
    quiet_inputs();
    cyc(0, 0);
    // 3: cores 0 and 2 alternate, then idle
    for (int r = 0; r < 4; r++) begin
      quiet_inputs();
      set_oe((r % 2) * 2, 2'b01);
      for (int i = 0; i < 4; i++) cyc(0, 0);
    end
    quiet_inputs();
    for (int i = 0; i < 2; i++) cyc(0, 0);
    // inactive codes 10/11 never win
    set_oe(0, 2'b10); set_oe(1, 2'b11);
    for (int i = 0; i < 2; i++) cyc(0, 0);
    quiet_inputs();
    // 4: request forwarding with ignored 2'b11
    set_req(2, 2'b01); set_req(3, 2'b01);
    cyc(0, 0); cyc(0, 0);
    set_req(2, 2'b11);
    cyc(0, 0); cyc(0, 0);
    set_req(3, 2'b00);
    cyc(0, 0); cyc(0, 0);
    // random traffic in RUN
    for (int i = 0; i < 300; i++) begin
      randomize_inputs(25);
      cyc(0, 0);
    end
    // 5: reset mid-launch at t0+12, then relaunch with random traffic
    quiet_inputs();
    cyc(1, 0);
    cyc(0, 0);
    set_oe(0, 2'b01); set_io(0, 32'hABCD);
    cyc(0, 1);
    for (int i = 0; i < 11; i++) cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 1);
    for (int i = 0; i < 40; i++) begin
      randomize_inputs(30);
      cyc(0, 0);
    end
`ifdef SSF_SCHED_COLLISION_CNT_EN
    // 6: five collision cycles, then saturation
    quiet_inputs();
    cyc(1, 0);
    launch_seq();
    set_oe(0, 2'b01); set_oe(1, 2'b01);
    for (int i = 0; i < 5; i++) cyc(0, 0);
    quiet_inputs();
    for (int i = 0; i < 3; i++) cyc(0, 0);
    set_oe(0, 2'b01); set_oe(1, 2'b01);
    for (int i = 0; i < 70000; i++) cyc(0, 0);
    quiet_inputs();
    for (int i = 0; i < 3; i++) cyc(0, 0);
`endif
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending entries, exp 0", exp_q.size());
    end
    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
